// File: rtl/prio_encoder8_to_3_seq_pkg.sv
// Shared types and default sizes for the registered priority encoder.
package prio_encoder8_to_3_seq_pkg;

    // Handshake FSM: IDLE looks for work, PRESENT holds a code until accepted.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int N_DEFAULT  = 8;
    localparam int CW_DEFAULT = 8;

endpackage

// File: rtl/prio_encoder8_to_3_seq_prio_enc_comb.sv
// Combinational N-to-W encoder: index of the highest set bit plus a nonzero flag.
module prio_enc_comb #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         nz
);

    // Scan upward so the highest set index is the last one written.
    always_comb begin
        // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

    assign nz = |req;

endmodule

// File: rtl/prio_encoder8_to_3_seq.sv
// Registered priority encoder with sticky request latching, a valid/ready
// handshake that grants one index at a time, and a saturating merge counter.
module prio_encoder8_to_3_seq
    import prio_encoder8_to_3_seq_pkg::*;
#(
    parameter  int N  = N_DEFAULT,
    parameter  int CW = CW_DEFAULT,
    localparam int W  = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  in,
    output logic [W-1:0]  out,
    output logic          valid,
    input  logic          ready,
    output logic [N-1:0]  pending,
    output logic          any,
    output logic [CW-1:0] merge_cnt
);

    // Popcount width and a sum width that can hold the counter plus one cycle's hits.
    localparam int PW = $clog2(N + 1);
    localparam int SW = ((CW > PW) ? CW : PW) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'({CW{1'b1}});

    state_t        state_q, state_d;
    logic [W-1:0]  out_q, out_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [CW-1:0] merge_q, merge_d;

    logic [N-1:0]  set;
    logic [N-1:0]  clr;
    logic [N-1:0]  merge_hits;
    logic [PW-1:0] merge_pop;
    logic [SW-1:0] merge_sum;
    logic          handshake;
    logic [W-1:0]  enc_idx;
    logic          enc_nz;

    // Highest pending index, looked up from the registered pending vector.
    prio_enc_comb #(.N(N)) u_enc (
        .req (pending_q),
        .idx (enc_idx),
        .nz  (enc_nz)
    );

    // Handshake FSM next-state: load a frozen code in IDLE, release it on ready.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        handshake = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_nz) begin
                    out_d   = enc_idx;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture and clear: a new pulse on the line being consumed wins over the clear.
    always_comb begin
        set        = en ? in : '0;
        clr        = handshake ? (N'(1) << out_q) : '0;
        pending_d  = (pending_q & ~clr) | set;
        merge_hits = set & pending_q & ~clr;
        merge_pop  = '0;
        for (int i = 0; i < N; i++) begin
            merge_pop = merge_pop + PW'(merge_hits[i]);
        end
        merge_sum = SW'(merge_q) + SW'(merge_pop);
        merge_d   = (merge_sum > CNT_MAX) ? {CW{1'b1}} : merge_sum[CW-1:0];
    end

    // State, presented code, pending vector and merge counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register here is a plain flop with a reset value; there is no memory array to leave unreset.
            state_q   <= IDLE;
            out_q     <= '0;
            pending_q <= '0;
            merge_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            out_q     <= out_d;
            pending_q <= pending_d;
            merge_q   <= merge_d;
        end
    end

    assign out       = out_q;
    assign valid     = (state_q == PRESENT);
    assign pending   = pending_q;
    assign any       = |pending_q;
    assign merge_cnt = merge_q;

endmodule
